// File: rtl/popcount_expander_pkg.sv
// Shared types and helpers for the popcount expander.
// Frame width, count width, FSM states and count clipping.
package popcount_pkg;

  localparam int FRAME_W_DEF = 12;
  localparam int CNT_W_DEF   = 4;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  // min(cnt, lim): counts above the frame width are clipped
  function automatic logic [15:0] clip_cnt(
    input logic [15:0] cnt,
    input logic [15:0] lim = 16'(FRAME_W_DEF)
  );
    return (cnt > lim) ? lim : cnt;
  endfunction

endpackage

// File: rtl/popcount_expander_if.sv
// Count-in / bit-out valid-ready bundle of the popcount expander.
// slave is the expander side, master is the upstream/downstream side.
interface popcount_expander_if
  import popcount_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             cnt_valid;
  logic             cnt_ready;
  logic [CNT_W-1:0] cnt_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_out;
  logic             bit_last;
  logic             sat_flag;

  modport slave (
    input  cnt_valid,
    input  cnt_in,
    input  bit_ready,
    output cnt_ready,
    output bit_valid,
    output bit_out,
    output bit_last,
    output sat_flag
  );

  modport master (
    output cnt_valid,
    output cnt_in,
    output bit_ready,
    input  cnt_ready,
    input  bit_valid,
    input  bit_out,
    input  bit_last,
    input  sat_flag
  );

endinterface

// File: rtl/popcount_expander_unary_bit_gen.sv
// Next unary bit generator: thermometer by default, Bresenham
// spread when POPCOUNT_EXPANDER_SPREAD_EN is defined.
module unary_bit_gen
  import popcount_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] i_n,
  output logic             o_bit
`ifdef POPCOUNT_EXPANDER_SPREAD_EN
  ,
  input  logic [CNT_W:0]   i_acc,
  output logic [CNT_W:0]   o_acc_nxt
`else
  ,
  input  logic [CNT_W-1:0] i_idx
`endif
);

`ifdef POPCOUNT_EXPANDER_SPREAD_EN
  localparam logic [CNT_W:0] FULL = (CNT_W+1)'(FRAME_W);

  logic [CNT_W:0] w_sum;

  // acc + n crossing the frame width emits a one and wraps acc
  always_comb begin
    w_sum     = {1'b0, i_n} + i_acc;
    o_bit     = (w_sum >= FULL);
    o_acc_nxt = o_bit ? (w_sum - FULL) : w_sum;
  end
`else
  // ones first, then zeros
  always_comb begin
    o_bit = (i_idx < i_n);
  end
`endif

endmodule

// File: rtl/popcount_expander.sv
// Popcount to unary frame expander, one bit per handshake.
// Option: POPCOUNT_EXPANDER_SPREAD_EN selects spread encoding.
module popcount_expander
  import popcount_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  popcount_expander_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FULL_N   = CNT_W'(FRAME_W);

  state_e           r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_idx;
  logic             r_bit_valid;
  logic             r_bit_out;
  logic             r_bit_last;
  logic             r_sat;

  logic             w_cnt_ready;
  logic             w_accept;
  logic             w_beat;
  logic             w_start;
  logic             w_gen_bit;
  logic [CNT_W-1:0] w_clip;
  logic [CNT_W-1:0] w_idx_inc;
  logic [CNT_W-1:0] w_gen_n;

  assign w_cnt_ready = (r_state == IDLE)
                     | ((r_state == EMIT) & r_bit_last & bus.bit_ready);
  assign w_accept    = bus.cnt_valid & w_cnt_ready;
  assign w_beat      = r_bit_valid & bus.bit_ready;
  assign w_clip      = CNT_W'(clip_cnt(16'(bus.cnt_in), 16'(FRAME_W)));
  assign w_idx_inc   = r_idx + CNT_W'(1);
  // a new frame starts from IDLE or right after the last beat
  assign w_start     = (r_state == IDLE) | r_bit_last;
  assign w_gen_n     = w_start ? w_clip : r_n;

`ifdef POPCOUNT_EXPANDER_SPREAD_EN
  logic [CNT_W:0] r_acc;
  logic [CNT_W:0] w_acc_in;
  logic [CNT_W:0] w_acc_nxt;

  assign w_acc_in = w_start ? '0 : r_acc;

  unary_bit_gen #(
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_gen (
    .i_n       (w_gen_n),
    .o_bit     (w_gen_bit),
    .i_acc     (w_acc_in),
    .o_acc_nxt (w_acc_nxt)
  );

  // accumulator tracks the beat whose bit is already registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_accept || (w_beat && !r_bit_last)) begin
      r_acc <= w_acc_nxt;
    end
  end
`else
  logic [CNT_W-1:0] w_gen_idx;

  assign w_gen_idx = w_start ? '0 : w_idx_inc;

  unary_bit_gen #(
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_gen (
    .i_n   (w_gen_n),
    .o_bit (w_gen_bit),
    .i_idx (w_gen_idx)
  );
`endif

  // frame FSM: load on accept, advance on beat, idle after last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_idx       <= '0;
      r_bit_valid <= 1'b0;
      r_bit_out   <= 1'b0;
      r_bit_last  <= 1'b0;
    end else if (w_accept) begin
      r_state     <= EMIT;
      r_n         <= w_clip;
      r_idx       <= '0;
      r_bit_valid <= 1'b1;
      r_bit_out   <= w_gen_bit;
      r_bit_last  <= (LAST_IDX == '0);
    end else if ((r_state == EMIT) && w_beat) begin
      if (r_bit_last) begin
        r_state     <= IDLE;
        r_idx       <= '0;
        r_bit_valid <= 1'b0;
        r_bit_out   <= 1'b0;
        r_bit_last  <= 1'b0;
      end else begin
        r_idx       <= w_idx_inc;
        r_bit_out   <= w_gen_bit;
        r_bit_last  <= (w_idx_inc == LAST_IDX);
      end
    end
  end

  // sticky flag for counts that had to be clipped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_accept && (bus.cnt_in > FULL_N)) begin
      r_sat <= 1'b1;
    end
  end

  assign bus.cnt_ready = w_cnt_ready;
  assign bus.bit_valid = r_bit_valid;
  assign bus.bit_out   = r_bit_out;
  assign bus.bit_last  = r_bit_last;
  assign bus.sat_flag  = r_sat;

endmodule
